// File: rtl/trig_capture_pkg.sv
// Shared types and helpers for the multi-channel trigger/capture sequencer.
package trig_capture_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitTrig,
    StSync,
    StCapture
  } state_e;

  localparam int unsigned MissW = 16;

  // Bit offset of a channel inside the packed sample word (channel 0 in the LSBs).
  function automatic int ch_lsb(int ch, int adc_w);
    return ch * adc_w;
  endfunction

endpackage

// File: rtl/trig_edge_detect.sv
// Registers the trigger level and produces a one-cycle pulse on the selected edge.
module trig_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  input  logic falling,
  output logic trig_edge
);

  logic last_trig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_trig <= 1'b0;
    end else begin
      last_trig <= trig;
    end
  end

  assign trig_edge = falling ? (~trig & last_trig) : (trig & ~last_trig);

endmodule

// File: rtl/trig_capture_fsm.sv
// Armed trigger sequencer: waits for an edge, skips the ADC pipeline latency, then streams
// decimated sample words to the capture-memory write port for N repetitions.
module trig_capture_fsm
  import trig_capture_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ADC_W       = 14,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned ADDR_STEP   = 4,
  parameter int unsigned ADC_LATENCY = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*ADC_W-1:0] adc_data,
  input  logic                    trig,
  input  logic                    trig_falling,
  input  logic                    arm,
  input  logic                    abort,
  input  logic [CNT_W-1:0]        max_sample_cnt,
  input  logic [CNT_W-1:0]        max_repetition_cnt,
  input  logic [7:0]              decim,
  input  logic [ADDR_W-1:0]       base_addr,
  output logic [NUM_CH*ADC_W-1:0] data_out,
  output logic                    write_enable,
  output logic [ADDR_W-1:0]       write_address,
  output logic                    busy,
  output logic                    done,
  output logic [MissW-1:0]        missed_trig_cnt
);

  localparam int unsigned DataW = NUM_CH * ADC_W;

  state_e             state;
  logic [CNT_W-1:0]   cfg_max_sample;
  logic [7:0]         cfg_decim;
  logic               cfg_falling;
  logic [CNT_W-1:0]   rep_cnt;
  logic [CNT_W-1:0]   sample_cnt;
  logic [7:0]         phase;
  logic [7:0]         delay;
  logic [ADDR_W-1:0]  ptr;
  logic               trig_edge;
  logic [DataW-1:0]   sample_word;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
    localparam int Lsb = ch_lsb(c, ADC_W);
    assign sample_word[Lsb +: ADC_W] = adc_data[Lsb +: ADC_W];
  end

  trig_edge_detect u_edge (
    .clk       (clk),
    .rst       (rst),
    .trig      (trig),
    .falling   (cfg_falling),
    .trig_edge (trig_edge)
  );

  assign busy = (state != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= StIdle;
      cfg_max_sample  <= '0;
      cfg_decim       <= '0;
      cfg_falling     <= 1'b0;
      rep_cnt         <= '0;
      sample_cnt      <= '0;
      phase           <= '0;
      delay           <= '0;
      ptr             <= '0;
      data_out        <= '0;
      write_enable    <= 1'b0;
      write_address   <= '0;
      done            <= 1'b0;
      missed_trig_cnt <= '0;
    end else begin
      write_enable <= 1'b0;
      done         <= 1'b0;
      // Edges arriving while a capture is already in flight are only counted.
      if ((state == StSync || state == StCapture) && trig_edge &&
          missed_trig_cnt != {MissW{1'b1}}) begin
        missed_trig_cnt <= missed_trig_cnt + MissW'(1);
      end
      if (abort) begin
        state <= StIdle;
      end else begin
        unique case (state)
          StIdle: begin
            if (arm) begin
              if (max_repetition_cnt == '0) begin
                done <= 1'b1;
              end else begin
                cfg_max_sample  <= max_sample_cnt;
                cfg_decim       <= decim;
                cfg_falling     <= trig_falling;
                rep_cnt         <= max_repetition_cnt;
                ptr             <= base_addr;
                missed_trig_cnt <= '0;
                state           <= StWaitTrig;
              end
            end
          end
          StWaitTrig: begin
            if (trig_edge) begin
              delay <= 8'(ADC_LATENCY - 1);
              state <= StSync;
            end
          end
          StSync: begin
            if (delay == 8'd0) begin
              data_out      <= sample_word;
              write_enable  <= 1'b1;
              write_address <= ptr;
              ptr           <= ptr + ADDR_W'(ADDR_STEP);
              sample_cnt    <= cfg_max_sample;
              phase         <= cfg_decim;
              state         <= StCapture;
            end else begin
              delay <= delay - 8'd1;
            end
          end
          StCapture: begin
            if (sample_cnt == '0) begin
              rep_cnt <= rep_cnt - CNT_W'(1);
              if (rep_cnt == CNT_W'(1)) begin
                done  <= 1'b1;
                state <= StIdle;
              end else begin
                state <= StWaitTrig;
              end
            end else if (phase == 8'd0) begin
              sample_cnt    <= sample_cnt - CNT_W'(1);
              phase         <= cfg_decim;
              data_out      <= sample_word;
              write_enable  <= 1'b1;
              write_address <= ptr;
              ptr           <= ptr + ADDR_W'(ADDR_STEP);
            end else begin
              phase <= phase - 8'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trig_capture_fsm.sv
// Scoreboard bench for trig_capture_fsm: stimulus queues expected writes/done pulses,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_trig_capture_fsm;

  localparam int unsigned NumCh = 2;
  localparam int unsigned AdcW  = 14;
  localparam int unsigned CntW  = 24;
  localparam int unsigned AddrW = 32;
  localparam int unsigned Step  = 4;
  localparam int unsigned Lat   = 6;
  localparam int unsigned DW    = NumCh * AdcW;

  logic             clk = 1'b0;
  logic             rst;
  logic [DW-1:0]    adc_data;
  logic             trig;
  logic             trig_falling;
  logic             arm;
  logic             abort;
  logic [CntW-1:0]  max_sample_cnt;
  logic [CntW-1:0]  max_repetition_cnt;
  logic [7:0]       decim;
  logic [AddrW-1:0] base_addr;
  logic [DW-1:0]    data_out;
  logic             write_enable;
  logic [AddrW-1:0] write_address;
  logic             busy;
  logic             done;
  logic [15:0]      missed_trig_cnt;

  trig_capture_fsm #(
    .NUM_CH      (NumCh),
    .ADC_W       (AdcW),
    .CNT_W       (CntW),
    .ADDR_W      (AddrW),
    .ADDR_STEP   (Step),
    .ADC_LATENCY (Lat)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .adc_data           (adc_data),
    .trig               (trig),
    .trig_falling       (trig_falling),
    .arm                (arm),
    .abort              (abort),
    .max_sample_cnt     (max_sample_cnt),
    .max_repetition_cnt (max_repetition_cnt),
    .decim              (decim),
    .base_addr          (base_addr),
    .data_out           (data_out),
    .write_enable       (write_enable),
    .write_address      (write_address),
    .busy               (busy),
    .done               (done),
    .missed_trig_cnt    (missed_trig_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Ramp: channel 0 = cycle index, channel 1 = 5*cycle+3, both truncated to 14 bits.
  function automatic logic [DW-1:0] ramp(int j);
    logic [13:0] c0;
    logic [13:0] c1;
    c0 = 14'(j);
    c1 = 14'(j * 5 + 3);
    return {c1, c0};
  endfunction

  assign adc_data = ramp(cyc);

  typedef struct {
    int               cyc;
    logic [AddrW-1:0] addr;
    logic [DW-1:0]    data;
  } wr_t;

  wr_t              exp_wr[$];
  int               exp_done[$];
  int               checks = 0;
  int               failures = 0;
  logic [AddrW-1:0] exp_ptr = '0;
  int               burst_end = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    int  dc;
    if (write_enable === 1'b1) begin
      checks++;
      if (exp_wr.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: cycle %0d addr %h data %h", cyc, write_address, data_out);
      end else begin
        e = exp_wr.pop_front();
        if (e.cyc != cyc || e.addr !== write_address || e.data !== data_out) begin
          failures++;
          $display("FAIL write: got cycle %0d addr %h data %h required cycle %0d addr %h data %h",
                   cyc, write_address, data_out, e.cyc, e.addr, e.data);
        end
      end
    end
    if (done === 1'b1) begin
      checks++;
      if (exp_done.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: cycle %0d", cyc);
      end else begin
        dc = exp_done.pop_front();
        if (dc != cyc || write_enable !== 1'b0) begin
          failures++;
          $display("FAIL done: got cycle %0d we %b required cycle %0d we 0", cyc, write_enable, dc);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Arms, then scrambles the configuration inputs so only the latched copy can be used.
  task automatic do_arm(int ms, int mr, int dec, logic [AddrW-1:0] base, logic fall);
    max_sample_cnt     = CntW'(ms);
    max_repetition_cnt = CntW'(mr);
    decim              = 8'(dec);
    base_addr          = base;
    trig_falling       = fall;
    arm                = 1'b1;
    if (mr != 0) exp_ptr = base;
    step(1);
    arm                = 1'b0;
    max_sample_cnt     = 24'h5;
    max_repetition_cnt = 24'h9;
    decim              = 8'h7;
    base_addr          = 32'hDEAD_0000;
    trig_falling       = ~fall;
  endtask

  task automatic push_writes(int k, int n, int dec);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.cyc  = k + Lat + 1 + i * (dec + 1);
      e.addr = exp_ptr;
      e.data = ramp(e.cyc - 1);
      exp_wr.push_back(e);
      exp_ptr = exp_ptr + Step;
    end
  endtask

  task automatic fire_burst(int ms, int dec, logic fall, bit last);
    int k = cyc;
    push_writes(k, ms + 1, dec);
    burst_end = k + Lat + 1 + ms * (dec + 1) + 1;
    if (last) exp_done.push_back(burst_end);
    trig = ~fall;
    step(1);
    trig = fall;
  endtask

  task automatic finish_burst();
    while (cyc <= burst_end) step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1; trig = 1'b0; trig_falling = 1'b0; arm = 1'b0; abort = 1'b0;
    max_sample_cnt = '0; max_repetition_cnt = '0; decim = '0; base_addr = '0;
    step(2);
    check("rst_we", write_enable, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_data", data_out, 0);
    check("rst_addr", write_address, 0);
    check("rst_missed", missed_trig_cnt, 0);
    rst = 1'b0;
    step(2);

    // Two repetitions of 4 back-to-back writes, addresses 0x100..0x11C.
    do_arm(3, 2, 0, 32'h100, 1'b0);
    check("busy_after_arm", busy, 1);
    step(2);
    fire_burst(3, 0, 1'b0, 1'b0);
    finish_burst();
    check("busy_between_reps", busy, 1);
    step(1);
    fire_burst(3, 0, 1'b0, 1'b1);
    finish_burst();
    check("busy_after_done", busy, 0);

    // Decimation 2: two writes three cycles apart.
    do_arm(1, 1, 2, 32'h200, 1'b0);
    step(2);
    fire_burst(1, 2, 1'b0, 1'b1);
    finish_burst();

    // Falling-edge mode: the rising edge must not start a capture.
    do_arm(2, 1, 0, 32'h500, 1'b1);
    step(1);
    trig = 1'b1;
    step(4);
    check("no_capture_on_rise", busy & write_enable, 0);
    fire_burst(2, 0, 1'b1, 1'b1);
    finish_burst();
    trig = 1'b0;
    step(2);

    // Three extra edges during SYNC/CAPTURE are counted and ignored.
    do_arm(7, 1, 1, 32'h600, 1'b0);
    step(2);
    fire_burst(7, 1, 1'b0, 1'b1);
    step(1); trig = 1'b1; step(1); trig = 1'b0;
    step(4); trig = 1'b1; step(1); trig = 1'b0;
    step(3); trig = 1'b1; step(1); trig = 1'b0;
    finish_burst();
    check("missed_cnt", missed_trig_cnt, 3);
    do_arm(7, 1, 0, 32'h700, 1'b0);
    check("missed_cleared", missed_trig_cnt, 0);

    // Abort together with arm in the middle of a capture.
    step(2);
    k = cyc;
    trig = 1'b1;
    push_writes(k, 3, 0);
    step(1);
    trig = 1'b0;
    step(8);
    abort = 1'b1; arm = 1'b1; max_repetition_cnt = 24'd3;
    step(1);
    abort = 1'b0; arm = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_we", write_enable, 0);
    step(5);
    check("abort_stays_idle", busy, 0);

    // Zero repetitions: immediate done, never busy.
    max_repetition_cnt = '0;
    arm = 1'b1;
    exp_done.push_back(cyc + 1);
    step(1);
    arm = 1'b0;
    check("rep0_busy", busy, 0);
    step(1);
    check("rep0_busy_later", busy, 0);

    // Address wrap-around: FFFFFFF8, FFFFFFFC, 00000000, 00000004.
    do_arm(3, 1, 0, 32'hFFFF_FFF8, 1'b0);
    step(2);
    fire_burst(3, 0, 1'b0, 1'b1);
    finish_burst();
    check("wrap_ptr_model", exp_ptr, 32'h0000_0008);

    // Asynchronous reset in the middle of a burst.
    do_arm(7, 1, 0, 32'h800, 1'b0);
    step(2);
    k = cyc;
    trig = 1'b1;
    push_writes(k, 2, 0);
    step(1);
    trig = 1'b0;
    step(8);
    check("we_before_rst", write_enable, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_we", write_enable, 0);
    check("arst_busy", busy, 0);
    check("arst_data", data_out, 0);
    check("arst_addr", write_address, 0);
    step(2);
    rst = 1'b0;
    step(3);
    check("post_rst_missed", missed_trig_cnt, 0);
    check("post_rst_busy", busy, 0);

    step(3);
    check("wr_queue_empty", exp_wr.size(), 0);
    check("done_queue_empty", exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
